// File: rtl/knn_feed_pkg.sv
// Shared types and sizing helpers for the KNN stream feeder.
package knn_feed_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NDIM_DEF   = 5;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE, REF_FILL, REF_SEND, SMP_FILL, SMP_SEND, NAME, DONE
  } feed_state_e;

  function automatic int buf_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/knn_vec_buf.sv
// One-vector register file: synchronous write port, combinational read port.
module knn_vec_buf #(
  parameter int dataWidth = 32,
  parameter int depth     = 5,
  parameter int idxWidth  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [idxWidth-1:0]  wrIdx,
  input  logic [dataWidth-1:0] wrData,
  input  logic [idxWidth-1:0]  rdIdx,
  output logic [dataWidth-1:0] rdData
);
  logic [depth-1:0][dataWidth-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (reset)   r_mem <= '0;
    else if (we) r_mem[wrIdx] <= wrData;
  end

  assign rdData = r_mem[rdIdx];
endmodule

// File: rtl/knn_stream_feeder.sv
// Buffers one vector from an upstream valid/ready stream and replays it in KNN framing.
// Optional macro KNN_FEED_PERF_CNT_EN adds the stallCycles counter output.
module knn_stream_feeder
  import knn_feed_pkg::*;
#(
  parameter int dataWidth          = DATA_W_DEF,
  parameter int numberOfDimensions = NDIM_DEF,
  parameter int countWidth         = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [dataWidth-1:0]  kIn,
  input  logic [countWidth-1:0] numSamples,
  input  logic [dataWidth-1:0]  s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  busy,
  output logic [dataWidth-1:0]  knnK,
  output logic                  knnLoadRef,
  output logic [dataWidth-1:0]  knnRefData,
  output logic [dataWidth-1:0]  knnDataValue,
  output logic [dataWidth-1:0]  knnDataName,
  output logic                  knnDone
`ifdef KNN_FEED_PERF_CNT_EN
  ,
  output logic [31:0]           stallCycles
`endif
);
  localparam int IW = buf_idx_w(numberOfDimensions);
  localparam logic [IW-1:0] LAST = IW'(numberOfDimensions - 1);

  feed_state_e r_state, w_next;
  logic [IW-1:0]         r_pos;
  logic [dataWidth-1:0]  r_k, r_refData, r_dataValue, r_dataName;
  logic [countWidth-1:0] r_numSamples, r_idx, w_idx_inc;
  logic                  r_loadRef, r_done;
  logic                  w_fill, w_hs, w_last, w_start_ok, w_send;
  logic [dataWidth-1:0]  w_rd;

  assign w_fill     = (r_state == REF_FILL) || (r_state == SMP_FILL);
  assign w_send     = (r_state == REF_SEND) || (r_state == SMP_SEND);
  assign w_hs       = w_fill && s_valid;
  assign w_last     = (r_pos == LAST);
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_idx_inc  = r_idx + 1'b1;

  // Fill and replay share one position counter; they never overlap in time.
  knn_vec_buf #(.dataWidth(dataWidth), .depth(numberOfDimensions), .idxWidth(IW)) u_buf (
    .clk    (clk),
    .reset  (reset),
    .we     (w_hs),
    .wrIdx  (r_pos),
    .wrData (s_data),
    .rdIdx  (r_pos),
    .rdData (w_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start)             w_next = REF_FILL;
      REF_FILL:   if (s_valid && w_last) w_next = REF_SEND;
      REF_SEND:   if (w_last)            w_next = (r_numSamples == '0) ? DONE : SMP_FILL;
      SMP_FILL:   if (s_valid && w_last) w_next = SMP_SEND;
      SMP_SEND:   if (w_last)            w_next = NAME;
      NAME:       w_next = (w_idx_inc == r_numSamples) ? DONE : SMP_FILL;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos        <= '0;
      r_k          <= '0;
      r_numSamples <= '0;
      r_idx        <= '0;
      r_loadRef    <= 1'b0;
      r_refData    <= '0;
      r_dataValue  <= '0;
      r_dataName   <= '0;
      r_done       <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_k          <= kIn;
        r_numSamples <= numSamples;
        r_idx        <= '0;
      end
      // Done rises the cycle after DONE is entered and clears on the accepting edge.
      r_done <= (r_state == DONE) && !start;
      if (w_hs || w_send) r_pos <= w_last ? '0 : r_pos + 1'b1;
      r_loadRef <= (r_state == REF_SEND);
      if (r_state == REF_SEND) r_refData   <= w_rd;
      if (r_state == SMP_SEND) r_dataValue <= w_rd;
      if (r_state == NAME) begin
        r_dataName <= dataWidth'(r_idx);
        r_idx      <= w_idx_inc;
      end
    end
  end

`ifdef KNN_FEED_PERF_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk) begin
    if (reset || w_start_ok)                   r_stall <= '0;
    else if (w_fill && !s_valid && r_stall != '1) r_stall <= r_stall + 1'b1;
  end
  assign stallCycles = r_stall;
`endif

  assign s_ready      = w_fill;
  assign busy         = (r_state != IDLE) && (r_state != DONE);
  assign knnK         = r_k;
  assign knnLoadRef   = r_loadRef;
  assign knnRefData   = r_refData;
  assign knnDataValue = r_dataValue;
  assign knnDataName  = r_dataName;
  assign knnDone      = r_done;
endmodule

// File: doc/knn_stream_feeder.md
Name: knn_stream_feeder

Overview:
Transmit-side driver for the KNN accelerator's load/stream interface. Pulls reference and sample words from an upstream valid/ready stream and buffers one full vector. Replays each vector contiguously, one word per clock, in the accelerator's framing: a loadRef burst, then per-sample value bursts with a name update, then done. Sits between the host/DMA FIFO and the KNN core.

Parameters:
dataWidth, 32, width of every data/reference word and of k
numberOfDimensions, 5, words per vector (>=1)
countWidth, 16, width of sample counter and sample name

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a job when idle
kIn  in  dataWidth  neighbour count, latched on accepted start
numSamples  in  countWidth  samples in job, latched on accepted start
s_data  in  dataWidth  upstream word
s_valid  in  1  upstream word valid
s_ready  out  1  feeder accepts word (handshake = s_valid & s_ready)
busy  out  1  high in every state except IDLE and DONE
knnK  out  dataWidth  latched k to core
knnLoadRef  out  1  reference-load strobe
knnRefData  out  dataWidth  reference word
knnDataValue  out  dataWidth  sample word
knnDataName  out  dataWidth  sample name (zero-extended index)
knnDone  out  1  end of job

Behaviour:
- Reset: all outputs 0, state IDLE, buffer and counters cleared; reset mid-job aborts immediately, no partial framing emitted afterwards.
- States: IDLE, REF_FILL, REF_SEND, SMP_FILL, SMP_SEND, NAME, DONE.
- IDLE: start -> latch kIn to knnK, numSamples, sample index = 0; next cycle REF_FILL.
- REF_FILL / SMP_FILL: s_ready=1; each handshake writes buffer[wrIdx], wrIdx++; after handshake numberOfDimensions, s_ready drops the next cycle and the state moves to REF_SEND / SMP_SEND. s_valid low = stall, no output change.
- REF_SEND: exactly numberOfDimensions cycles, knnLoadRef=1, knnRefData=buffer[i] for i=0..N-1. Then knnLoadRef=0, knnRefData holds the last word. Next state SMP_FILL, or DONE if numSamples==0.
- SMP_SEND: exactly N cycles, knnDataValue=buffer[i]; no gaps. knnDataValue holds the last word until the next SMP_SEND.
- NAME: one cycle; knnDataName=sample index, then index++. Last sample -> DONE, else SMP_FILL.
- Outputs are registered; first word appears the cycle after the state is entered.
- DONE: knnDone=1, held until the next accepted start (which clears it the same edge) or reset; all other knn outputs hold.
- start while busy or in same cycle as reset: ignored. start in DONE: accepted.
- s_ready=0 in all SEND/NAME/IDLE/DONE states; upstream data there is not consumed.
- Index counter wraps modulo 2^countWidth; knnDataName zero-extends.

Optional Feature:
KNN_FEED_PERF_CNT_EN: defined -> extra output stallCycles [31:0], cleared on reset and accepted start, +1 each FILL-state cycle with s_valid=0, saturates at all-ones. Undefined -> port and logic absent, behaviour otherwise identical.

Decomposition:
- Package knn_feed_pkg: state enum, default width constants, helper for buffer index width (clog2 of numberOfDimensions, min 1).
- Sub-module knn_vec_buf: N x dataWidth register file with write port (we, wrIdx) and combinational read port (rdIdx). It is instantiated once and owns no control.

Test Plan:
- Reset mid REF_SEND (cycle 2 of 5) -> next cycle all outputs 0, s_ready 0, busy 0; later start runs a clean job.
- N=5, k=3, numSamples=4, ref {1,2,2,2,3}, samples {5,10,7,9,6},{1x5},{2x5},{5x5}, s_valid always 1 -> knnK=3; knnLoadRef high 5 consecutive cycles with 1,2,2,2,3; each sample burst 5 contiguous cycles followed by a name cycle 0,1,2,3; knnDone=1 after name 3.
- Same job, s_valid toggled 1/0 -> identical output sequence except longer FILL gaps; no knn output changes during stalls; stallCycles equals the low-valid FILL cycles (macro on).
- numSamples=0 -> after ref burst, directly DONE; knnDataName/knnDataValue stay 0.
- start pulsed during SMP_SEND -> ignored, job unchanged; start in DONE -> knnDone clears, new kIn latched.
- s_valid held high during SEND/NAME -> s_ready 0, upstream word not consumed; first word of next FILL is that held word.
